alu_arbiter: RTL
================

# alu_arbiter

Round-robin arbiter and sequencer that shares one combinational 8-bit ALU between two requesters. Each requester presents an operand pair and a 4-bit operation select on a valid/ready handshake. The block grants one request at a time, drives the ALU for one cycle, registers the result and carry, and returns it on a single response channel tagged with the requester ID. It sits between the two datapath clients and the ALU instance.

## Interface
- DATA_W, 8, operand and result width
- SEL_W, 4, operation select width; codes 0–7 valid, codes 8–15 illegal
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req0_valid / req1_valid  input  1  request valid
- req0_ready / req1_ready  output  1  request accepted this cycle when valid&ready
- req0_a, req0_b / req1_a, req1_b  input  DATA_W  operands
- req0_sel / req1_sel  input  SEL_W  ALU operation code
- alu_a, alu_b  output  DATA_W  operands to ALU
- alu_sel  output  SEL_W  operation to ALU
- alu_out  input  DATA_W  ALU result (combinational)
- alu_carry  input  1  ALU carry/borrow
- rsp_valid  output  1  response valid, held until rsp_ready
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester that owns the response (0/1)
- rsp_data  output  DATA_W  registered result
- rsp_carry  output  1  carry; meaningful only for sel 0 (add) and 1 (sub), else 0
- rsp_err  output  1  illegal sel (sel[3]=1)
- busy  output  1  high in any state but IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: req0_ready/req1_ready=1 only for the granted requester when it has valid high; otherwise 0. On handshake, latch a, b, sel, id; go to EXEC.
- Arbitration: if exactly one valid, grant it. If both valid, grant the one not granted last (pointer last_id). last_id updates on each accepted request.
- EXEC: drive alu_a/alu_b/alu_sel from latched values. Capture rsp_data=alu_out and rsp_carry=alu_carry if sel∈{0,1}, else rsp_carry=0. Go to RESP.
- Illegal sel (sel[3]=1): EXEC still occupies one cycle. ALU inputs are forced to 0 with alu_sel=0. Capture rsp_data=0, rsp_carry=0, rsp_err=1.
- RESP: rsp_valid=1. rsp_id/data/carry/err stay stable until rsp_valid&rsp_ready, then go to IDLE. No request is accepted in EXEC or RESP.
- Outside EXEC: alu_a=alu_b=0 and alu_sel=0.

## Timing
- Reset (rst high at a clock edge): state=IDLE, last_id=1 so req0 wins the first contention. All outputs 0: both readys, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err, busy, alu_*.
- Reset mid-operation: the in-flight request is discarded and no response is issued.
- Latency: accept at edge T; EXEC during cycle T+1; rsp_valid high from cycle T+2.
- Throughput with rsp_ready tied high: one op per 3 cycles.
- Back-pressure: with rsp_ready low, the block stays in RESP indefinitely with outputs stable.
- Ready is a combinational function of state, valids and last_id. It never depends on rsp_ready.
- Requester valid dropping without a handshake is legal; nothing is latched.

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration as described.
- ALU_ARB_RR_EN undefined: fixed priority. req0 always wins contention, and last_id is unused, which allows req1 to starve.

## Test plan
- Single add: req0 a=0xF0, b=0x20, sel=0 → rsp_valid 2 cycles after accept, rsp_id=0, rsp_data=0x10, rsp_carry=1, rsp_err=0.
- Contention: both valid continuously; req0 sel=2 (AND) and req1 sel=3 (OR) with a=0xCC, b=0xAA → responses alternate id 0,1,0,1 with data 0x88 and 0xEE. Without ALU_ARB_RR_EN → all ids 0.
- Illegal op: req1 sel=9 → rsp_id=1, rsp_data=0x00, rsp_carry=0, rsp_err=1, same latency. alu_sel=0 during EXEC.
- Back-pressure: rsp_ready low for 5 cycles with req1 valid → rsp fields stable, req1_ready=0 throughout. Raise rsp_ready → req1 accepted the following IDLE cycle.
- Non-carry op: sel=5 (NOT), a=0x0F, preceded by sub 0x01-0x02 → first rsp_data=0xFF, rsp_carry=1; second rsp_data=0xF0, rsp_carry=0.
- Reset during EXEC: assert rst one cycle → no rsp_valid and all outputs 0. The next contention is granted to req0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 8-bit ALU between two requesters.
// Each accepted request gets one EXEC cycle on the ALU. The registered result
// comes back on a single response channel, tagged with the owner's ID.
// Build option: define ALU_ARB_RR_EN for round-robin contention handling.
// Without ALU_ARB_RR_EN, req0 always wins contention (fixed priority).
module alu_arbiter #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                id_q, id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_carry_q, rsp_carry_d;
  logic                rsp_err_q, rsp_err_d;
`ifdef ALU_ARB_RR_EN
  logic                last_id_q, last_id_d;
`endif

  logic                grant0;
  logic                grant1;
  logic                illegal;
  logic                carry_op;
  logic                exec_legal;

  // Choose a winner among the valid requesters. This is independent of the FSM state.
  always_comb begin
`ifdef ALU_ARB_RR_EN
    grant0 = req0_valid && (!req1_valid || last_id_q);
    grant1 = req1_valid && (!req0_valid || !last_id_q);
`else
    grant0 = req0_valid;
    grant1 = req1_valid && !req0_valid;
`endif
  end

  // Accept only in IDLE, and never while reset is being applied.
  assign req0_ready = (state_q == IDLE) && !rst && grant0;
  assign req1_ready = (state_q == IDLE) && !rst && grant1;

  // The top select bit marks an illegal operation.
  // Carry is only meaningful for add (0) and sub (1).
  assign illegal    = sel_q[SEL_W-1];
  assign carry_op   = (sel_q[SEL_W-1:1] == '0);
  assign exec_legal = (state_q == EXEC) && !illegal;

  // Drive the ALU only during a legal EXEC cycle. Otherwise it sees add of zeros.
  assign alu_a   = exec_legal ? a_q   : '0;
  assign alu_b   = exec_legal ? b_q   : '0;
  assign alu_sel = exec_legal ? sel_q : '0;

  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;

  // Next-state logic: accept -> execute on the shared ALU -> hold the response.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_err_d   = rsp_err_q;
`ifdef ALU_ARB_RR_EN
    last_id_d   = last_id_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          id_d    = req1_ready;
          a_d     = req1_ready ? req1_a   : req0_a;
          b_d     = req1_ready ? req1_b   : req0_b;
          sel_d   = req1_ready ? req1_sel : req0_sel;
`ifdef ALU_ARB_RR_EN
          last_id_d = req1_ready;
`endif
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_err_d   = illegal;
        rsp_data_d  = illegal ? '0 : alu_out;
        rsp_carry_d = !illegal && carry_op && alu_carry;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_id_d    = 1'b0;
          rsp_data_d  = '0;
          rsp_carry_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and response registers. Reset discards any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef ALU_ARB_RR_EN
      last_id_q   <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_err_q   <= rsp_err_d;
`ifdef ALU_ARB_RR_EN
      last_id_q   <= last_id_d;
`endif
    end
  end

endmodule
